sram_sdram_bridge: RTL
======================

Name: sram_sdram_bridge

Overview:
- Sits between the core's asynchronous-SRAM-style bus (CE/OE/WE, 23-bit address, 8-bit data) and the SDRAM controller's single-cycle request interface (rd/we pulses, ready level).
- Synchronises the core's strobes and detects new accesses.
- Issues exactly one SDRAM request per access and returns read data with a ready flag.
- Arbitrates ROM download writes (ioctl) ahead of core traffic. Runs in the SDRAM controller's clock domain.

Parameters:
- SYNC_STAGES, 2, flops on sram_ce_n/sram_oe_n/sram_we_n before edge detection (min 2).
- TIMEOUT, 255, max cycles waiting for sd_ready before abort (8-bit counter).

Ports:
- clk_sys  in  1  SDRAM-domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- sram_addr  in  23  core address; sampled at access detection.
- sram_din  in  8  core write data; sampled at access detection.
- sram_ce_n  in  1  core chip enable, active-low, asynchronous to clk_sys.
- sram_oe_n  in  1  core read strobe, active-low, asynchronous.
- sram_we_n  in  1  core write strobe, active-low, asynchronous.
- sram_q  out  8  read data, held until next read completes.
- sram_rdy  out  1  high = no core access pending.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  one-cycle download write strobe.
- ioctl_addr  in  23  download address.
- ioctl_data  in  8  download data.
- sd_addr  out  23  SDRAM request address.
- sd_din  out  8  SDRAM write data.
- sd_rd  out  1  one-cycle read request.
- sd_we  out  1  one-cycle write request.
- sd_dout  in  8  SDRAM read data, valid when sd_ready rises after sd_rd.
- sd_ready  in  1  high = controller idle / last request complete.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (reset_n low, any state, immediate): state IDLE; sram_q=0, sram_rdy=1, sd_rd=0, sd_we=0, sd_addr=0, sd_din=0, err=0; sync chains set to 1; pending flag cleared; timeout counter 0.
- Access detection uses synchronised strobes s_ce, s_oe, s_we.
  - Core write: falling edge of s_we while s_ce low.
  - Core read: falling edge of s_oe while s_ce low and s_we high.
  - Both edges in the same cycle: treated as a write.
- On detection, sram_rdy drops the next cycle and rises on the cycle the access completes.
- Download: ioctl_wr while ioctl_download=1 sets a one-deep pending slot holding ioctl_addr/ioctl_data.
  - A second ioctl_wr while the slot is full overwrites it. Upstream guarantees at least 16 cycles between strobes, so this does not occur in normal operation.
- Core detections during download are remembered (one-deep) and serviced after download-pending traffic drains. Download always wins arbitration in IDLE.
- States:
  - IDLE: priority order is download pending, then core write, then core read.
    - Load sd_addr/sd_din, then go to WR_REQ or RD_REQ.
  - WR_REQ / RD_REQ: assert sd_we / sd_rd for exactly one cycle, clear the counter, go to WAIT.
  - WAIT: the first cycle after REQ ignores sd_ready (controller latency). Thereafter, on sd_ready=1:
    - Read: sram_q <= sd_dout.
    - Release sram_rdy for core accesses, or clear the pending slot for downloads.
    - Return to IDLE.
    - Counter increments each cycle. On reaching TIMEOUT: set err, complete the access with sram_q unchanged, return to IDLE.
- Latency: detection to sd_rd/sd_we = 2 cycles from IDLE. The one-cycle completion at sd_ready makes the minimum core read turnaround 5 cycles plus SYNC_STAGES.
- ioctl_download falling mid-operation: the current request completes normally; a pending slot already latched is still written.
- A core strobe released before service: the captured access is still performed (writes are never dropped).
- sd_rd and sd_we are never high simultaneously and never high for more than one consecutive cycle.

Test Plan:
- Core write: addr=23'h012345, din=8'hA5, WE low 10 cycles with sd_ready modelled at 3-cycle latency.
  - Expect exactly one sd_we pulse with sd_addr=012345 and sd_din=A5.
  - sram_rdy low then high; sd_rd never asserted.
- Core read: controller returns 8'h3C for addr 23'h000100.
  - Expect one sd_rd pulse, sram_q=3C, and sram_rdy high the cycle after sd_ready rises.
- Download burst: ioctl_download=1 with 4 ioctl_wr strobes 16 cycles apart to addr 0..3, data 11,22,33,44, plus a core read issued mid-burst.
  - Expect 4 sd_we pulses in order, then the core read serviced after the last.
- Simultaneous OE and WE fall: expect a single sd_we and no sd_rd.
- sd_ready held low: expect err=1 after 255 wait cycles, sram_rdy returning high, sram_q unchanged, and the next access still serviced.
- Reset mid-read: assert reset_n low during WAIT.
  - Expect immediate sram_rdy=1, sd_rd=0, sram_q=0, and state IDLE.
  - No spurious request after release while strobes stay high.

Source files
------------

// File: rtl/sram_sdram_bridge.sv
// Bridges an asynchronous SRAM-style core bus onto a single-cycle SDRAM request port.
// ROM download writes take priority over core traffic.
module sram_sdram_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [22:0] sram_addr,
    input  logic [7:0]  sram_din,
    input  logic        sram_ce_n,
    input  logic        sram_oe_n,
    input  logic        sram_we_n,
    output logic [7:0]  sram_q,
    output logic        sram_rdy,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [22:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic [22:0] sd_addr,
    output logic [7:0]  sd_din,
    output logic        sd_rd,
    output logic        sd_we,
    input  logic [7:0]  sd_dout,
    input  logic        sd_ready,
    output logic        err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR_REQ = 2'd1;
    localparam logic [1:0] ST_RD_REQ = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] ce_sync_q, oe_sync_q, we_sync_q;
    logic                   oe_prev_q, we_prev_q;
    logic                   s_ce, s_oe, s_we, det_wr, det_rd;

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        core_pend_q, core_pend_d, core_wr_q, core_wr_d;
    logic [22:0] core_addr_q, core_addr_d;
    logic [7:0]  core_din_q, core_din_d;
    logic        dl_pend_q, dl_pend_d;
    logic [22:0] dl_addr_q, dl_addr_d;
    logic [7:0]  dl_data_q, dl_data_d;
    logic        cur_dl_q, cur_dl_d, cur_rd_q, cur_rd_d;
    logic [7:0]  q_q, q_d;
    logic        rdy_q, rdy_d, err_q, err_d, done;
    logic        sd_rd_q, sd_rd_d, sd_we_q, sd_we_d;
    logic [22:0] sd_addr_q, sd_addr_d;
    logic [7:0]  sd_din_q, sd_din_d;

    assign s_ce = ce_sync_q[SYNC_STAGES-1];
    assign s_oe = oe_sync_q[SYNC_STAGES-1];
    assign s_we = we_sync_q[SYNC_STAGES-1];

    // A write edge masks a read edge in the same cycle because det_rd requires s_we high.
    assign det_wr = we_prev_q & ~s_we & ~s_ce;
    assign det_rd = oe_prev_q & ~s_oe & ~s_ce & s_we;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_pend_d = core_pend_q;
        core_wr_d   = core_wr_q;
        core_addr_d = core_addr_q;
        core_din_d  = core_din_q;
        dl_pend_d   = dl_pend_q;
        dl_addr_d   = dl_addr_q;
        dl_data_d   = dl_data_q;
        cur_dl_d    = cur_dl_q;
        cur_rd_d    = cur_rd_q;
        q_d         = q_q;
        rdy_d       = rdy_q;
        err_d       = err_q;
        sd_addr_d   = sd_addr_q;
        sd_din_d    = sd_din_q;
        sd_rd_d     = 1'b0;
        sd_we_d     = 1'b0;
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dl_pend_q) begin
                    sd_addr_d = dl_addr_q;
                    sd_din_d  = dl_data_q;
                    cur_dl_d  = 1'b1;
                    cur_rd_d  = 1'b0;
                    sd_we_d   = 1'b1;
                    state_d   = ST_WR_REQ;
                end else if (core_pend_q && !ioctl_download) begin
                    sd_addr_d   = core_addr_q;
                    sd_din_d    = core_din_q;
                    cur_dl_d    = 1'b0;
                    cur_rd_d    = ~core_wr_q;
                    core_pend_d = 1'b0;
                    sd_we_d     = core_wr_q;
                    sd_rd_d     = ~core_wr_q;
                    state_d     = core_wr_q ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ, ST_RD_REQ: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            default: begin
                cnt_d = cnt_q + 8'd1;
                // cnt_q == 0 marks the controller-latency cycle where sd_ready is stale.
                if (cnt_q != 8'd0 && sd_ready) begin
                    if (cur_rd_q) q_d = sd_dout;
                    done = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    err_d = 1'b1;
                    done  = 1'b1;
                end
                if (done) begin
                    state_d = ST_IDLE;
                    if (cur_dl_q) dl_pend_d = 1'b0;
                    else if (!core_pend_q) rdy_d = 1'b1;
                end
            end
        endcase

        if (ioctl_download && ioctl_wr) begin
            dl_pend_d = 1'b1;
            dl_addr_d = ioctl_addr;
            dl_data_d = ioctl_data;
        end

        if (det_wr || det_rd) begin
            core_pend_d = 1'b1;
            core_wr_d   = det_wr;
            core_addr_d = sram_addr;
            core_din_d  = sram_din;
            rdy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ce_sync_q   <= '1;
            oe_sync_q   <= '1;
            we_sync_q   <= '1;
            oe_prev_q   <= 1'b1;
            we_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            core_pend_q <= 1'b0;
            core_wr_q   <= 1'b0;
            core_addr_q <= '0;
            core_din_q  <= '0;
            dl_pend_q   <= 1'b0;
            dl_addr_q   <= '0;
            dl_data_q   <= '0;
            cur_dl_q    <= 1'b0;
            cur_rd_q    <= 1'b0;
            q_q         <= '0;
            rdy_q       <= 1'b1;
            err_q       <= 1'b0;
            sd_rd_q     <= 1'b0;
            sd_we_q     <= 1'b0;
            sd_addr_q   <= '0;
            sd_din_q    <= '0;
        end else begin
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], sram_ce_n};
            oe_sync_q   <= {oe_sync_q[SYNC_STAGES-2:0], sram_oe_n};
            we_sync_q   <= {we_sync_q[SYNC_STAGES-2:0], sram_we_n};
            oe_prev_q   <= s_oe;
            we_prev_q   <= s_we;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            core_pend_q <= core_pend_d;
            core_wr_q   <= core_wr_d;
            core_addr_q <= core_addr_d;
            core_din_q  <= core_din_d;
            dl_pend_q   <= dl_pend_d;
            dl_addr_q   <= dl_addr_d;
            dl_data_q   <= dl_data_d;
            cur_dl_q    <= cur_dl_d;
            cur_rd_q    <= cur_rd_d;
            q_q         <= q_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            sd_rd_q     <= sd_rd_d;
            sd_we_q     <= sd_we_d;
            sd_addr_q   <= sd_addr_d;
            sd_din_q    <= sd_din_d;
        end
    end

    assign sram_q   = q_q;
    assign sram_rdy = rdy_q;
    assign sd_addr  = sd_addr_q;
    assign sd_din   = sd_din_q;
    assign sd_rd    = sd_rd_q;
    assign sd_we    = sd_we_q;
    assign err      = err_q;

endmodule
